// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/execute/memory/writeback sequencer for the 16-bit core.
// Define SEQ_PERF_CNT_EN to add the retired / stall_cycles performance counters.
module cpu_seq_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic       ir_load,
    output logic       pc_en,
    output logic       pc_sel,
    output logic       rt_sel,
    output logic       rd_sel,
    output logic       rf_wen,
    output logic       mem_req,
    output logic       ram_wen,
    output logic       busy,
    output logic       halted,
    output logic       mem_err,
    output logic [2:0] state
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0] retired,
    output logic [15:0] stall_cycles
`endif
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
        MEM = 3'd4, WB = 3'd5, HALT = 3'd6, ILL = 3'd7
    } state_e;

    state_e           state_q, state_d, eoi;
    logic [3:0]       op_q, op_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             is_r, is_addi, is_jmp, is_lw, is_sw, is_nop, tmo;

    assign is_r    = !op_q[3];
    assign is_addi = op_q == 4'h8;
    assign is_jmp  = op_q == 4'h9;
    assign is_lw   = op_q == 4'hA;
    assign is_sw   = op_q == 4'hB;
    assign is_nop  = op_q >= 4'hC && op_q != 4'hF;
    assign eoi     = run ? FETCH : IDLE;
    // Timeout fires on the MEM cycle after MEM_TIMEOUT ready-less cycles; mem_req is already dropped then
    assign tmo     = (MEM_TIMEOUT != 0) && (cnt_q == TMO_W'(MEM_TIMEOUT));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = '0;
        err_d   = err_q;
        ir_load = 1'b0;
        pc_en   = 1'b0;
        pc_sel  = 1'b0;
        rt_sel  = 1'b0;
        rd_sel  = 1'b0;
        rf_wen  = 1'b0;
        mem_req = 1'b0;
        ram_wen = 1'b0;
        case (state_q)
            IDLE:   state_d = (run || step) ? FETCH : IDLE;
            FETCH: begin
                ir_load = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                op_d    = opcode;
                state_d = (opcode == 4'hF) ? HALT : EXEC;
            end
            EXEC: begin
                rt_sel  = is_addi || is_lw || is_sw;
                pc_en   = is_jmp || is_nop;
                pc_sel  = is_jmp;
                state_d = (is_r || is_addi) ? WB : (is_lw || is_sw) ? MEM : eoi;
            end
            MEM: begin
                rd_sel  = is_lw;
                mem_req = !tmo;
                ram_wen = is_sw && !tmo;
                pc_en   = is_sw && mem_ready && !tmo;
                cnt_d   = cnt_q + {{(TMO_W-1){1'b0}}, !mem_ready};
                if (tmo) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else if (mem_ready) begin
                    state_d = is_lw ? WB : eoi;
                end
            end
            WB: begin
                rf_wen  = 1'b1;
                pc_en   = 1'b1;
                rd_sel  = is_lw;
                state_d = eoi;
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy    = state_q != IDLE && state_q != HALT;
    assign halted  = state_q == HALT;
    assign mem_err = err_q;
    assign state   = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] ret_q, stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_q   <= '0;
            stall_q <= '0;
        end else begin
            ret_q   <= ret_q + {15'd0, pc_en};
            stall_q <= stall_q + {15'd0, state_q == MEM && !mem_ready};
        end
    end

    assign retired      = ret_q;
    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed bench for cpu_seq_ctrl with hand-computed state/enable expectations.
module tb_cpu_seq_ctrl;
    logic       clk = 1'b0, rst = 1'b1, run = 1'b0, step = 1'b0, mem_ready = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       ir_load, pc_en, pc_sel, rt_sel, rd_sel, rf_wen, mem_req, ram_wen;
    logic       busy, halted, mem_err;
    logic [2:0] state;
    logic [7:0] ctl;
    int         tests = 0, fails = 0;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] retired, stall_cycles;
`endif

    cpu_seq_ctrl #(.MEM_TIMEOUT(15), .TMO_W(8)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode), .mem_ready(mem_ready),
        .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel), .rt_sel(rt_sel), .rd_sel(rd_sel),
        .rf_wen(rf_wen), .mem_req(mem_req), .ram_wen(ram_wen), .busy(busy), .halted(halted),
        .mem_err(mem_err), .state(state)
`ifdef SEQ_PERF_CNT_EN
        , .retired(retired), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // ctl order: ir_load pc_en pc_sel rt_sel rd_sel rf_wen mem_req ram_wen
    assign ctl = {ir_load, pc_en, pc_sel, rt_sel, rd_sel, rf_wen, mem_req, ram_wen};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ex(input string tag, input logic [2:0] st, input logic [7:0] c);
        chk(tag, {5'd0, state, ctl}, {5'd0, st, c});
    endtask

    task automatic stat(input string tag, input logic [2:0] bhe);
        chk(tag, {13'd0, busy, halted, mem_err}, {13'd0, bhe});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        ex("reset", 3'd0, 8'b0000_0000);
        stat("reset_stat", 3'b000);
        repeat (3) tick();
        ex("idle_hold", 3'd0, 8'b0000_0000);

        // single-step R-type
        opcode = 4'h3; step = 1'b1;
        tick(); step = 1'b0;
        ex("r_fetch", 3'd1, 8'b1000_0000);
        stat("r_busy", 3'b100);
        tick(); ex("r_decode", 3'd2, 8'b0000_0000);
        tick(); ex("r_exec", 3'd3, 8'b0000_0000);
        tick(); ex("r_wb", 3'd5, 8'b0100_0100);
        tick(); ex("r_idle", 3'd0, 8'b0000_0000);
        tick(); ex("r_idle2", 3'd0, 8'b0000_0000);

        // free-run R, ADDI, JUMP
        run = 1'b1; opcode = 4'h1;
        tick(); ex("run_f1", 3'd1, 8'b1000_0000);
        tick(); ex("run_d1", 3'd2, 8'b0000_0000);
        tick(); ex("run_e1", 3'd3, 8'b0000_0000);
        tick(); ex("run_w1", 3'd5, 8'b0100_0100);
        opcode = 4'h8;
        tick(); ex("run_f2", 3'd1, 8'b1000_0000);
        tick(); ex("run_d2", 3'd2, 8'b0000_0000);
        tick(); ex("addi_exec", 3'd3, 8'b0001_0000);
        tick(); ex("addi_wb", 3'd5, 8'b0100_0100);
        opcode = 4'h9;
        tick(); ex("run_f3", 3'd1, 8'b1000_0000);
        tick(); ex("run_d3", 3'd2, 8'b0000_0000);
        tick(); ex("jump_exec", 3'd3, 8'b0110_0000);
        run = 1'b0;
        tick(); ex("jump_idle", 3'd0, 8'b0000_0000);
`ifdef SEQ_PERF_CNT_EN
        chk("retired", retired, 16'd4);
`endif

        // LW with ready on the fourth MEM cycle
        opcode = 4'hA; step = 1'b1;
        tick(); step = 1'b0;
        ex("lw_fetch", 3'd1, 8'b1000_0000);
        tick(); ex("lw_decode", 3'd2, 8'b0000_0000);
        tick(); ex("lw_exec", 3'd3, 8'b0001_0000);
        tick(); ex("lw_mem1", 3'd4, 8'b0000_1010);
        tick(); ex("lw_mem2", 3'd4, 8'b0000_1010);
        tick(); ex("lw_mem3", 3'd4, 8'b0000_1010);
        tick(); ex("lw_mem4", 3'd4, 8'b0000_1010);
        mem_ready = 1'b1; #1;
        ex("lw_mem4_rdy", 3'd4, 8'b0000_1010);
        tick(); mem_ready = 1'b0;
        ex("lw_wb", 3'd5, 8'b0100_1100);
        tick(); ex("lw_idle", 3'd0, 8'b0000_0000);

        // SW with ready in the first MEM cycle
        opcode = 4'hB; step = 1'b1;
        tick(); step = 1'b0;
        tick(); ex("sw_decode", 3'd2, 8'b0000_0000);
        tick(); ex("sw_exec", 3'd3, 8'b0001_0000);
        tick(); ex("sw_mem_wait", 3'd4, 8'b0000_0011);
        mem_ready = 1'b1; #1;
        ex("sw_mem_rdy", 3'd4, 8'b0100_0011);
        tick(); mem_ready = 1'b0;
        ex("sw_idle", 3'd0, 8'b0000_0000);

        // SW timeout: 15 requesting cycles, then a dropped-request cycle, then HALT
        opcode = 4'hB; step = 1'b1;
        tick(); step = 1'b0;
        tick(); tick();
        ex("tmo_exec", 3'd3, 8'b0001_0000);
        for (int i = 0; i < 15; i++) begin
            tick(); ex($sformatf("tmo_wait%0d", i), 3'd4, 8'b0000_0011);
        end
        stat("tmo_noerr_yet", 3'b100);
        tick(); ex("tmo_expire", 3'd4, 8'b0000_0000);
        tick(); ex("tmo_halt", 3'd6, 8'b0000_0000);
        stat("tmo_stat", 3'b011);
        run = 1'b1; step = 1'b1;
        tick(); run = 1'b0; step = 1'b0;
        tick(); run = 1'b1;
        tick(); run = 1'b0;
        ex("halt_absorb", 3'd6, 8'b0000_0000);
        stat("halt_absorb_stat", 3'b011);
        #2 rst = 1'b1; #1;
        ex("tmo_rst", 3'd0, 8'b0000_0000);
        stat("tmo_rst_stat", 3'b000);
        tick(); rst = 1'b0;

        // HALT opcode
        opcode = 4'hF; step = 1'b1;
        tick(); step = 1'b0;
        tick(); ex("hlt_decode", 3'd2, 8'b0000_0000);
        tick(); ex("hlt_state", 3'd6, 8'b0000_0000);
        stat("hlt_stat", 3'b010);
        #2 rst = 1'b1; #1;
        ex("hlt_rst", 3'd0, 8'b0000_0000);
        tick(); rst = 1'b0;

        // async reset mid-LW
        opcode = 4'hA; step = 1'b1;
        tick(); step = 1'b0;
        tick(); tick(); tick();
        ex("arst_mem", 3'd4, 8'b0000_1010);
        #2 rst = 1'b1; #1;
        ex("arst_idle", 3'd0, 8'b0000_0000);
        stat("arst_stat", 3'b000);
        tick(); rst = 1'b0;

        // step pulse during EXEC is ignored
        opcode = 4'h3; step = 1'b1;
        tick(); step = 1'b0;
        tick(); tick();
        ex("stp_exec", 3'd3, 8'b0000_0000);
        step = 1'b1;
        tick(); step = 1'b0;
        ex("stp_wb", 3'd5, 8'b0100_0100);
        tick(); ex("stp_idle", 3'd0, 8'b0000_0000);
        tick(); ex("stp_idle2", 3'd0, 8'b0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
